// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the MIPS datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the
// per-step datapath controls, waits in MEM for the DM handshake, counts
// retired instructions and parks in a sticky FAULT state on a hung access.
module multicycle_ctrl #(
  parameter int WATCHDOG = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  instr_op,
  input  logic [5:0]  instr_func,
  input  logic        cmp_result,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  npc_op,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [2:0]  data_to_reg,
  output logic [1:0]  ext_op,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic [31:0] retired,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_JR, C_OTHER
  } class_e;

  // The counter value in the MEM cycle whose stall would bring it to WATCHDOG
  localparam logic [7:0] WD_LAST = 8'(WATCHDOG - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] retired_q, retired_d;
  class_e      cls;

  // Classify the instruction held in IR; anything unrecognised retires as a no-op
  always_comb begin
    cls = C_OTHER;
    case (instr_op)
      6'h00: begin
        if (instr_func == 6'h20)      cls = C_ADD;
        else if (instr_func == 6'h22) cls = C_SUB;
        else if (instr_func == 6'h08) cls = C_JR;
      end
      6'h0D:   cls = C_ORI;
      6'h0F:   cls = C_LUI;
      6'h23:   cls = C_LW;
      6'h2B:   cls = C_SW;
      6'h04:   cls = C_BEQ;
      6'h03:   cls = C_JAL;
      default: cls = C_OTHER;
    endcase
  end

  // State, MEM wait counter and retirement counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Next-state: step sequence per instruction class, MEM handshake and watchdog
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (cls == C_JAL)        state_d = S_WB;
        else if (cls == C_OTHER) state_d = S_FETCH;
        else                     state_d = S_EXEC;
      end
      S_EXEC: begin
        case (cls)
          C_ADD, C_SUB, C_ORI, C_LUI: state_d = S_WB;
          C_LW, C_SW:                 state_d = S_MEM;
          default:                    state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready)              state_d = (cls == C_LW) ? S_WB : S_FETCH;
        else if (wait_q == WD_LAST) state_d = S_FAULT;
        else                        state_d = S_MEM;
      end
      S_WB:    state_d = S_FETCH;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
  end

  // Wait counter runs only across stalled MEM cycles and is zero on MEM entry
  always_comb begin
    wait_d = 8'd0;
    if (state_q == S_MEM && !mem_ready) wait_d = wait_q + 8'd1;
  end

  // Retirement count advances on every PC update and wraps naturally
  always_comb begin
    retired_d = retired_q + {31'd0, pc_write};
  end

  // Per-state enables plus datapath selects held steady from EXEC through WB
  always_comb begin
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    npc_op      = 2'b00;
    reg_write   = 1'b0;
    reg_dst     = 2'b00;
    data_to_reg = 3'b000;
    ext_op      = 2'b00;
    alu_src     = 1'b0;
    alu_op      = 3'b000;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (cls)
        C_SUB: alu_op = 3'b001;
        C_ORI: begin ext_op = 2'b00; alu_src = 1'b1; alu_op = 3'b010; reg_dst = 2'b01; end
        C_LUI: begin ext_op = 2'b10; alu_src = 1'b1; alu_op = 3'b011; reg_dst = 2'b01; end
        C_LW:  begin ext_op = 2'b01; alu_src = 1'b1; reg_dst = 2'b01; data_to_reg = 3'b001; end
        C_SW:  begin ext_op = 2'b01; alu_src = 1'b1; end
        C_BEQ: alu_op = 3'b001;
        C_JAL: begin reg_dst = 2'b10; data_to_reg = 3'b010; end
        default: ;
      endcase
    end
    case (state_q)
      S_FETCH: ir_write = 1'b1;
      S_DECODE: begin
        if (cls == C_OTHER) pc_write = 1'b1;
      end
      S_EXEC: begin
        if (cls == C_BEQ) begin
          pc_write = 1'b1;
          npc_op   = cmp_result ? 2'b01 : 2'b00;
        end else if (cls == C_JR) begin
          pc_write = 1'b1;
          npc_op   = 2'b11;
        end
      end
      S_MEM: begin
        mem_read  = (cls == C_LW);
        mem_write = (cls == C_SW);
        pc_write  = (cls == C_SW) && mem_ready;
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        npc_op    = (cls == C_JAL) ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  assign state      = state_q;
  assign instr_done = pc_write;
  assign retired    = retired_q;
  assign fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven vectors, hand-written corner sequences
// and randomized instruction streams checked against a latency-based model.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  instr_op;
  logic [5:0]  instr_func;
  logic        cmp_result;
  logic        mem_ready;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  npc_op;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [2:0]  data_to_reg;
  logic [1:0]  ext_op;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  state;
  logic        instr_done;
  logic [31:0] retired;
  logic        fault;

  int vectors;
  int miscompares;

  multicycle_ctrl #(.WATCHDOG(16)) dut (
    .clk(clk), .reset(reset), .instr_op(instr_op), .instr_func(instr_func),
    .cmp_result(cmp_result), .mem_ready(mem_ready), .ir_write(ir_write),
    .pc_write(pc_write), .npc_op(npc_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .data_to_reg(data_to_reg), .ext_op(ext_op), .alu_src(alu_src), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .state(state), .instr_done(instr_done),
    .retired(retired), .fault(fault)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of inputs plus expected outputs; mask selects which selects are checked
  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    logic       cmp;
    logic       rdy;
    logic [2:0] st;
    logic       ir, pc, rw, mr, mw, flt;
    logic [5:0] mask;
    logic [1:0] npc;
    logic [1:0] dst;
    logic [2:0] dtr;
    logic [1:0] ext;
    logic       src;
    logic [2:0] alu;
  } vec_t;

  function automatic vec_t rowv(input logic [5:0] op, input logic [5:0] func,
      input logic cmp, input logic rdy, input logic [2:0] st,
      input logic ir, input logic pc, input logic rw, input logic mr, input logic mw,
      input logic flt, input logic [5:0] mask, input logic [1:0] npc,
      input logic [1:0] dst, input logic [2:0] dtr, input logic [1:0] ext,
      input logic src, input logic [2:0] alu);
    vec_t v;
    v.op = op; v.func = func; v.cmp = cmp; v.rdy = rdy; v.st = st;
    v.ir = ir; v.pc = pc; v.rw = rw; v.mr = mr; v.mw = mw; v.flt = flt;
    v.mask = mask; v.npc = npc; v.dst = dst; v.dtr = dtr; v.ext = ext;
    v.src = src; v.alu = alu;
    return v;
  endfunction

  function automatic vec_t fetchRow(input logic [5:0] op, input logic [5:0] func);
    return rowv(op, func, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0, 6'b0, 2'b0, 2'b0, 3'b0, 2'b0, 0, 3'b0);
  endfunction

  function automatic vec_t decodeRow(input logic [5:0] op, input logic [5:0] func);
    return rowv(op, func, 0, 0, 3'd1, 0, 0, 0, 0, 0, 0, 6'b0, 2'b0, 2'b0, 3'b0, 2'b0, 0, 3'b0);
  endfunction

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] func,
                               input logic cmp, input logic rdy);
    instr_op   = op;
    instr_func = func;
    cmp_result = cmp;
    mem_ready  = rdy;
  endtask

  task automatic checkOutput(input vec_t v, input string name);
    logic [9:0]  act_ctl, exp_ctl;
    logic [12:0] act_sel, exp_sel;
    act_ctl = {state, ir_write, pc_write, reg_write, mem_read, mem_write, fault, instr_done};
    exp_ctl = {v.st, v.ir, v.pc, v.rw, v.mr, v.mw, v.flt, v.pc};
    act_sel = {npc_op & {2{v.mask[5]}}, reg_dst & {2{v.mask[4]}}, data_to_reg & {3{v.mask[3]}},
               ext_op & {2{v.mask[2]}}, alu_src & v.mask[1], alu_op & {3{v.mask[0]}}};
    exp_sel = {v.npc & {2{v.mask[5]}}, v.dst & {2{v.mask[4]}}, v.dtr & {3{v.mask[3]}},
               v.ext & {2{v.mask[2]}}, v.src & v.mask[1], v.alu & {3{v.mask[0]}}};
    vectors++;
    if (act_ctl !== exp_ctl || act_sel !== exp_sel) begin
      miscompares++;
      $display("[TB] FAIL %s: got ctl=%h sel=%h, expected ctl=%h sel=%h",
               name, act_ctl, act_sel, exp_ctl, exp_sel);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one row just after a rising edge, check at the falling edge, advance
  task automatic runCycle(input vec_t v, input string name);
    applyStimulus(v.op, v.func, v.cmp, v.rdy);
    @(negedge clk);
    checkOutput(v, name);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(6'h00, 6'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput(fetchRow(6'h00, 6'h00), "reset_hold");
    checkValue("reset_retired", retired, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Hard bound on the whole run
  initial begin
    #300000;
    $display("[TB] FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  vec_t tbl[$];
  vec_t v;
  int   cls, w, len, exp_ret;
  logic [5:0] op, fn;
  logic c;
  logic writer, is_mem, in_mem;
  int   base[10];

  // Main stimulus
  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    applyStimulus(6'h00, 6'h00, 1'b0, 1'b0);
    base = '{4, 4, 4, 4, 5, 4, 3, 3, 3, 2};
    #2;
    doReset();

    // mask bits: npc, reg_dst, data_to_reg, ext_op, alu_src, alu_op
    tbl.push_back(fetchRow(6'h00, 6'h20));
    tbl.push_back(decodeRow(6'h00, 6'h20));
    tbl.push_back(rowv(6'h00, 6'h20, 0, 1, 3'd2, 0, 0, 0, 0, 0, 0, 6'b000011, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000));
    tbl.push_back(rowv(6'h00, 6'h20, 0, 1, 3'd4, 0, 1, 1, 0, 0, 0, 6'b111000, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000));
    tbl.push_back(fetchRow(6'h00, 6'h22));
    tbl.push_back(decodeRow(6'h00, 6'h22));
    tbl.push_back(rowv(6'h00, 6'h22, 0, 0, 3'd2, 0, 0, 0, 0, 0, 0, 6'b000011, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b001));
    tbl.push_back(rowv(6'h00, 6'h22, 0, 0, 3'd4, 0, 1, 1, 0, 0, 0, 6'b111000, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000));
    tbl.push_back(fetchRow(6'h0D, 6'h00));
    tbl.push_back(decodeRow(6'h0D, 6'h00));
    tbl.push_back(rowv(6'h0D, 6'h00, 0, 0, 3'd2, 0, 0, 0, 0, 0, 0, 6'b000111, 2'b00, 2'b00, 3'b000, 2'b00, 1, 3'b010));
    tbl.push_back(rowv(6'h0D, 6'h00, 0, 0, 3'd4, 0, 1, 1, 0, 0, 0, 6'b110000, 2'b00, 2'b01, 3'b000, 2'b00, 0, 3'b000));
    tbl.push_back(fetchRow(6'h0F, 6'h00));
    tbl.push_back(decodeRow(6'h0F, 6'h00));
    tbl.push_back(rowv(6'h0F, 6'h00, 0, 0, 3'd2, 0, 0, 0, 0, 0, 0, 6'b000111, 2'b00, 2'b00, 3'b000, 2'b10, 1, 3'b011));
    tbl.push_back(rowv(6'h0F, 6'h00, 0, 0, 3'd4, 0, 1, 1, 0, 0, 0, 6'b110000, 2'b00, 2'b01, 3'b000, 2'b00, 0, 3'b000));
    tbl.push_back(rowv(6'h23, 6'h00, 0, 1, 3'd0, 1, 0, 0, 0, 0, 0, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000));
    tbl.push_back(rowv(6'h23, 6'h00, 0, 1, 3'd1, 0, 0, 0, 0, 0, 0, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000));
    tbl.push_back(rowv(6'h23, 6'h00, 0, 1, 3'd2, 0, 0, 0, 0, 0, 0, 6'b000111, 2'b00, 2'b00, 3'b000, 2'b01, 1, 3'b000));
    for (int i = 0; i < 3; i++)
      tbl.push_back(rowv(6'h23, 6'h00, 0, 0, 3'd3, 0, 0, 0, 1, 0, 0, 6'b0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000));
    tbl.push_back(rowv(6'h23, 6'h00, 0, 1, 3'd3, 0, 0, 0, 1, 0, 0, 6'b0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000));
    tbl.push_back(rowv(6'h23, 6'h00, 0, 0, 3'd4, 0, 1, 1, 0, 0, 0, 6'b111000, 2'b00, 2'b01, 3'b001, 2'b00, 0, 3'b000));
    tbl.push_back(fetchRow(6'h04, 6'h00));
    tbl.push_back(decodeRow(6'h04, 6'h00));
    tbl.push_back(rowv(6'h04, 6'h00, 1, 0, 3'd2, 0, 1, 0, 0, 0, 0, 6'b100001, 2'b01, 2'b00, 3'b000, 2'b00, 0, 3'b001));
    tbl.push_back(fetchRow(6'h04, 6'h00));
    tbl.push_back(decodeRow(6'h04, 6'h00));
    tbl.push_back(rowv(6'h04, 6'h00, 0, 0, 3'd2, 0, 1, 0, 0, 0, 0, 6'b100001, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b001));
    tbl.push_back(fetchRow(6'h03, 6'h00));
    tbl.push_back(decodeRow(6'h03, 6'h00));
    tbl.push_back(rowv(6'h03, 6'h00, 0, 0, 3'd4, 0, 1, 1, 0, 0, 0, 6'b111000, 2'b10, 2'b10, 3'b010, 2'b00, 0, 3'b000));
    tbl.push_back(fetchRow(6'h3F, 6'h00));
    tbl.push_back(rowv(6'h3F, 6'h00, 0, 0, 3'd1, 0, 1, 0, 0, 0, 0, 6'b100000, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000));
    tbl.push_back(fetchRow(6'h00, 6'h08));
    tbl.push_back(decodeRow(6'h00, 6'h08));
    tbl.push_back(rowv(6'h00, 6'h08, 0, 0, 3'd2, 0, 1, 0, 0, 0, 0, 6'b100000, 2'b11, 2'b00, 3'b000, 2'b00, 0, 3'b000));
    tbl.push_back(fetchRow(6'h2B, 6'h00));
    tbl.push_back(decodeRow(6'h2B, 6'h00));
    tbl.push_back(rowv(6'h2B, 6'h00, 0, 0, 3'd2, 0, 0, 0, 0, 0, 0, 6'b000111, 2'b00, 2'b00, 3'b000, 2'b01, 1, 3'b000));
    tbl.push_back(rowv(6'h2B, 6'h00, 0, 0, 3'd3, 0, 0, 0, 0, 1, 0, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000));
    tbl.push_back(rowv(6'h2B, 6'h00, 0, 1, 3'd3, 0, 1, 0, 0, 1, 0, 6'b100000, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000));

    for (int i = 0; i < tbl.size(); i++) runCycle(tbl[i], $sformatf("tbl%0d", i));
    checkValue("tbl_retired", retired, 32'd11);

    // Watchdog: one nop, then a store that never completes
    doReset();
    runCycle(fetchRow(6'h3F, 6'h00), "wd_nop_f");
    runCycle(rowv(6'h3F, 6'h00, 0, 0, 3'd1, 0, 1, 0, 0, 0, 0, 6'b100000, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000), "wd_nop_d");
    runCycle(fetchRow(6'h2B, 6'h00), "wd_sw_f");
    runCycle(decodeRow(6'h2B, 6'h00), "wd_sw_d");
    runCycle(rowv(6'h2B, 6'h00, 0, 0, 3'd2, 0, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000), "wd_sw_e");
    for (int i = 0; i < 16; i++)
      runCycle(rowv(6'h2B, 6'h00, 0, 0, 3'd3, 0, 0, 0, 0, 1, 0, 6'b0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000),
               $sformatf("wd_mem%0d", i));
    for (int i = 0; i < 3; i++)
      runCycle(rowv(6'h2B, 6'h00, 0, 1, 3'd7, 0, 0, 0, 0, 0, 1, 6'b0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000),
               $sformatf("wd_fault%0d", i));
    checkValue("wd_retired", retired, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput(fetchRow(6'h2B, 6'h00), "wd_reset_clear");
    checkValue("wd_reset_retired", retired, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset asserted while a load is stalled in MEM
    runCycle(fetchRow(6'h23, 6'h00), "abort_f");
    runCycle(decodeRow(6'h23, 6'h00), "abort_d");
    runCycle(rowv(6'h23, 6'h00, 0, 0, 3'd2, 0, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000), "abort_e");
    runCycle(rowv(6'h23, 6'h00, 0, 0, 3'd3, 0, 0, 0, 1, 0, 0, 6'b0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000), "abort_m0");
    runCycle(rowv(6'h23, 6'h00, 0, 0, 3'd3, 0, 0, 0, 1, 0, 0, 6'b0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000), "abort_m1");
    reset = 1'b1;
    #1;
    checkOutput(fetchRow(6'h23, 6'h00), "abort_reset");
    checkValue("abort_retired", retired, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Retirement counter wrap: preload just below all-ones, then retire nops
    force dut.retired_q = 32'hFFFF_FFFE;
    #1;
    release dut.retired_q;
    for (int i = 0; i < 2; i++) begin
      runCycle(fetchRow(6'h3F, 6'h00), "wrap_f");
      runCycle(rowv(6'h3F, 6'h00, 0, 0, 3'd1, 0, 1, 0, 0, 0, 0, 6'b100000, 2'b00, 2'b00, 3'b000, 2'b00, 0, 3'b000), "wrap_d");
      checkValue($sformatf("wrap_retired%0d", i), retired, (i == 0) ? 32'hFFFF_FFFF : 32'h0000_0000);
    end

    // Randomized instruction stream against a latency/position model
    doReset();
    exp_ret = 0;
    for (int n = 0; n < 60; n++) begin
      cls = (n == 0) ? 4 : (n == 1) ? 5 : int'($urandom_range(0, 9));
      w = (n < 2 || $urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4));
      c = 1'($urandom_range(0, 1));
      fn = 6'h00;
      case (cls)
        0: begin op = 6'h00; fn = 6'h20; end
        1: begin op = 6'h00; fn = 6'h22; end
        2: op = 6'h0D;
        3: op = 6'h0F;
        4: op = 6'h23;
        5: op = 6'h2B;
        6: op = 6'h04;
        7: op = 6'h03;
        8: begin op = 6'h00; fn = 6'h08; end
        default: begin
          op = 6'($urandom_range(0, 63));
          fn = 6'($urandom_range(0, 63));
          if (op == 6'h00 || op == 6'h03 || op == 6'h04 || op == 6'h0D ||
              op == 6'h0F || op == 6'h23 || op == 6'h2B) op = 6'h00;
          if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h08)) fn = 6'h00;
        end
      endcase
      writer = (cls <= 4) || (cls == 7);
      is_mem = (cls == 4) || (cls == 5);
      len = base[cls] + (is_mem ? w : 0);
      for (int k = 0; k < len; k++) begin
        in_mem = is_mem && (k >= 3) && (k <= 3 + w);
        v = fetchRow(op, fn);
        v.cmp = c;
        v.rdy = in_mem ? (k == 3 + w) : 1'($urandom_range(0, 1));
        v.ir  = (k == 0);
        v.pc  = (k == len - 1);
        v.rw  = writer && (k == len - 1);
        v.mr  = in_mem && (cls == 4);
        v.mw  = in_mem && (cls == 5);
        if (k == 0)                       v.st = 3'd0;
        else if (k == 1)                  v.st = 3'd1;
        else if (in_mem)                  v.st = 3'd3;
        else if (writer && k == len - 1)  v.st = 3'd4;
        else                              v.st = 3'd2;
        if (k == len - 1) begin
          v.mask = 6'b100000;
          v.npc = (cls == 6) ? {1'b0, c} : (cls == 7) ? 2'b10 : (cls == 8) ? 2'b11 : 2'b00;
        end
        runCycle(v, $sformatf("rnd%0d_cls%0d_c%0d", n, cls, k));
      end
      exp_ret++;
      checkValue($sformatf("rnd%0d_retired", n), retired, 32'(exp_ret));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the MIPS datapath: it splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps, drives per-step control to PC, IR, GRF, EXT, ALU, NPC and DM, and stalls in MEM until data memory signals ready. It replaces the single-cycle combinational controller when the datapath gains an instruction register and a handshaking DM. It also counts retired instructions and traps a hung memory access into a sticky fault state.

## Interface
- WATCHDOG, 16: maximum MEM-state cycles without mem_ready before FAULT (legal range 1..255).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces FETCH and clears counters.
- instr_op  in  6  opcode from IR (instr[31:26]).
- instr_func  in  6  function field from IR (instr[5:0]).
- cmp_result  in  1  ALU equality compare result (beq).
- mem_ready  in  1  DM handshake: access completes this cycle.
- ir_write  out  1  load IR from IM.
- pc_write  out  1  load PC from NPC.
- npc_op  out  2  00 PC+4, 01 branch, 10 jal target, 11 jr (rs).
- reg_write  out  1  GRF write enable.
- reg_dst  out  2  00 rd, 01 rt, 10 $31.
- data_to_reg  out  3  000 ALU, 001 DM, 010 PC+4.
- ext_op  out  2  00 zero-ext, 01 sign-ext, 10 load-upper.
- alu_src  out  1  0 rt, 1 EXT output.
- alu_op  out  3  000 add, 001 sub, 010 or, 011 pass-B (lui).
- mem_read  out  1  DM read request.
- mem_write  out  1  DM write request.
- state  out  3  current state encoding.
- instr_done  out  1  pulse: instruction retires this cycle (equals pc_write).
- retired  out  32  retired-instruction count.
- fault  out  1  sticky watchdog fault.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7; 5 and 6 unused and go to FETCH.
- FETCH: ir_write=1, all other enables 0; next DECODE.
- Decode is combinational from instr_op/instr_func, which are valid from DECODE onward.
- Sequences, with pc_write in the last state listed:
  - add (op 0, func 0x20) / sub (func 0x22): F,D,E,WB; reg_dst=00, alu_src=0, alu_op add/sub, data_to_reg=000.
  - ori (0x0D): F,D,E,WB; ext_op=00, alu_src=1, alu_op=010, reg_dst=01.
  - lui (0x0F): F,D,E,WB; ext_op=10, alu_src=1, alu_op=011, reg_dst=01.
  - lw (0x23): F,D,E,M,WB; ext_op=01, alu_src=1, add; mem_read in M; data_to_reg=001, reg_dst=01 in WB.
  - sw (0x2B): F,D,E,M; mem_write held through M; pc_write in the M cycle where mem_ready=1.
  - beq (0x04): F,D,E; alu_op=sub; npc_op=01 if cmp_result else 00.
  - jal (0x03): F,D,WB; reg_dst=10, data_to_reg=010, npc_op=10.
  - jr (op 0, func 0x08): F,D,E; npc_op=11.
  - any other encoding (includes nop): F,D; pc_write in D with npc_op=00, no other effect.
- reg_write is asserted only in WB. mem_read and mem_write are asserted only in MEM.
- MEM behaviour:
  - A wait counter clears on MEM entry and increments each cycle mem_ready=0.
  - mem_ready=1 leaves MEM (to WB for lw, to FETCH for sw).
  - When the counter reaches WATCHDOG, go to FAULT without asserting pc_write.
- FAULT: all enables 0, fault=1, stays in FAULT until reset.
- retired increments by 1 whenever pc_write=1 and wraps from 0xFFFFFFFF to 0.
- Unless a step states otherwise, the step after pc_write is FETCH.

## Timing
- Reset values: state=FETCH, retired=0, fault=0, wait counter=0. Outputs are combinational from state and decode, so ir_write=1 while reset is held.
- Reset deasserted or asserted mid-instruction: takes effect immediately; pending DM handshake is abandoned; no partial write is counted.
- Latency in cycles: ALU/lui/ori 4, lw 5+w, sw 4+w (w = mem_ready wait cycles), beq/jr 3, jal 3, nop 2.
- mem_ready is sampled only in MEM; it is ignored in other states.
- If mem_ready=1 in the same cycle the counter reaches WATCHDOG, the access completes and no fault is raised.
- instr_done and pc_write are single-cycle pulses, one per retired instruction.

## Test plan
- Reset, then add $3=$1+$2 with mem_ready held 1 -> state 0,1,2,4,0; reg_write and pc_write both high only in cycle 4; retired=1.
- lw with mem_ready low 3 cycles, then high -> 3 extra MEM cycles with mem_read=1; WB has data_to_reg=001; total 8 cycles.
- beq with cmp_result=1, then with cmp_result=0 -> EXEC cycle shows npc_op=01, then 00; 3 cycles each; no reg_write.
- sw with mem_ready held low, WATCHDOG=16 -> after 16 MEM cycles state=7, fault=1, mem_write=0; retired unchanged; reset returns to state 0 with fault=0.
- jal, then unknown opcode 0x3F -> jal: WB at cycle 3 with reg_dst=10, data_to_reg=010, npc_op=10; unknown: retires in 2 cycles, no writes.
- reset asserted mid-MEM of lw -> state=0 immediately with no reg_write; retired preloaded to 0xFFFFFFFF by a run of nops wraps to 0 on the next retirement.
